// File: rtl/text_console_pkg.sv
// Shared definitions for the text console: command codes, geometry
// defaults, FSM state and the cursor operation selector.
package text_console_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;
    localparam logic [3:0] DEFAULT_BLANK = 4'h0;

    localparam int ADDR_W  = 12;
    localparam int GLYPH_W = 4;
    localparam int CODE_W  = 5;

    // Codes 0..15 print the glyph of the same value; 20..31 are consumed silently
    typedef enum logic [CODE_W-1:0] {
        CMD_GLYPH_LO = 5'd0,
        CMD_GLYPH_HI = 5'd15,
        CMD_NEWLINE  = 5'd16,
        CMD_BKSP     = 5'd17,
        CMD_CLEAR    = 5'd18,
        CMD_HOME     = 5'd19
    } cmd_code_e;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADVANCE,
        OP_NEWLINE,
        OP_RETREAT,
        OP_HOME
    } cursor_op_e;

    // Glyph codes are exactly those with the top bit clear
    function automatic logic is_glyph(input logic [CODE_W-1:0] code);
        return ~code[CODE_W-1];
    endfunction

endpackage

// File: rtl/text_console_cursor.sv
// Cursor position tracker. Keeps column, row and the matching linear cell
// address in lockstep so the write address never needs a multiplier.
module text_cursor
    import text_console_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  cursor_op_e        op,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] write_addr,
    output logic              at_origin
);

    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] col_ext;

    assign col_ext   = ADDR_W'(col);
    assign at_origin = (addr == '0);

    // A retreat writes the cell it lands on; everything else writes under the cursor
    assign write_addr = (op == OP_RETREAT) ? addr - ADDR_W'(1) : addr;

    // Apply the requested move to column, row and linear address together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else begin
            unique case (op)
                OP_ADVANCE: begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        if (row == LAST_ROW) begin
                            row  <= '0;
                            addr <= '0;
                        end else begin
                            row  <= row + ROW_W'(1);
                            addr <= addr + ADDR_W'(1);
                        end
                    end else begin
                        col  <= col + COL_W'(1);
                        addr <= addr + ADDR_W'(1);
                    end
                end
                OP_NEWLINE: begin
                    col <= '0;
                    if (row == LAST_ROW) begin
                        row  <= '0;
                        addr <= '0;
                    end else begin
                        row  <= row + ROW_W'(1);
                        addr <= addr + (COLS_A - col_ext);
                    end
                end
                OP_RETREAT: begin
                    if (!at_origin) begin
                        if (col == '0) begin
                            col <= LAST_COL;
                            row <= row - ROW_W'(1);
                        end else begin
                            col <= col - COL_W'(1);
                        end
                        addr <= addr - ADDR_W'(1);
                    end
                end
                OP_HOME: begin
                    col  <= '0;
                    row  <= '0;
                    addr <= '0;
                end
                default: begin
                    col  <= col;
                    row  <= row;
                    addr <= addr;
                end
            endcase
        end
    end

endmodule

// File: rtl/text_console.sv
// Command-driven console front end. Accepts glyph/control commands over a
// valid/ready handshake, moves the cursor and issues one registered write
// per cycle into the text buffer. A full-screen blank runs after reset and
// on every clear command; commands are held off while it runs.
module text_console
    import text_console_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS,
    parameter logic [GLYPH_W-1:0] BLANK = DEFAULT_BLANK,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CODE_W-1:0]  cmd_code,
    output logic [GLYPH_W-1:0] new_char,
    output logic [ADDR_W-1:0]  waddr,
    output logic               text_en,
    output logic [COL_W-1:0]   cursor_col,
    output logic [ROW_W-1:0]   cursor_row
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    state_e            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              accept;
    cursor_op_e        op;
    logic [ADDR_W-1:0] cur_write_addr;
    logic              at_origin;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .col        (cursor_col),
        .row        (cursor_row),
        .write_addr (cur_write_addr),
        .at_origin  (at_origin)
    );

    // Translate an accepted command into a cursor move; clear also homes the cursor
    always_comb begin
        op = OP_NONE;
        if (accept) begin
            if (is_glyph(cmd_code)) begin
                op = OP_ADVANCE;
            end else begin
                case (cmd_code)
                    CMD_NEWLINE:         op = OP_NEWLINE;
                    CMD_BKSP:            op = at_origin ? OP_NONE : OP_RETREAT;
                    CMD_CLEAR, CMD_HOME: op = OP_HOME;
                    default:             op = OP_NONE;
                endcase
            end
        end
    end

    // Control FSM: runs the blanking sweep and registers the text buffer write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            text_en  <= 1'b0;
            waddr    <= '0;
            new_char <= '0;
        end else begin
            text_en <= 1'b0;
            unique case (state)
                ST_CLEAR: begin
                    text_en  <= 1'b1;
                    waddr    <= clr_cnt;
                    new_char <= BLANK;
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (is_glyph(cmd_code)) begin
                            text_en  <= 1'b1;
                            waddr    <= cur_write_addr;
                            new_char <= cmd_code[GLYPH_W-1:0];
                        end else if (cmd_code == CMD_BKSP && !at_origin) begin
                            text_en  <= 1'b1;
                            waddr    <= cur_write_addr;
                            new_char <= BLANK;
                        end else if (cmd_code == CMD_CLEAR) begin
                            // Address 0 goes out on the accept edge; the sweep continues from 1
                            text_en  <= 1'b1;
                            waddr    <= '0;
                            new_char <= BLANK;
                            state    <= ST_CLEAR;
                            clr_cnt  <= ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Testbench for text_console: directed command sequences with a write
// scoreboard fed by the stimulus and drained by a negedge monitor.
`timescale 1ns/1ps
module tb_text_console;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam logic [3:0] BLANK = 4'h0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_code = 5'd0;
    logic [3:0] new_char;
    logic [11:0] waddr;
    logic       text_en;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    always #5 clk = ~clk;

    text_console #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .new_char   (new_char),
        .waddr      (waddr),
        .text_en    (text_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  m_col = 0;
    int  m_row = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkCursor(input string name, input int c, input int r);
        checkOutput({name, " col"}, int'(cursor_col), c);
        checkOutput({name, " row"}, int'(cursor_row), r);
    endtask

    task automatic pushWrite(input int a, input int d);
        exp_q.push_back('{a, d});
    endtask

    // Reference behaviour using absolute row*COLS+col addressing
    task automatic modelCmd(input int code);
        if (code < 16) begin
            pushWrite(m_row * COLS + m_col, code);
            if (m_col < COLS - 1) m_col++;
            else begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
        end else if (code == 16) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end else if (code == 17) begin
            if (m_col > 0) begin
                m_col--;
                pushWrite(m_row * COLS + m_col, BLANK);
            end else if (m_row > 0) begin
                m_col = COLS - 1;
                m_row--;
                pushWrite(m_row * COLS + m_col, BLANK);
            end
        end else if (code == 18) begin
            for (int i = 0; i < CELLS; i++) pushWrite(i, BLANK);
            m_col = 0;
            m_row = 0;
        end else if (code == 19) begin
            m_col = 0;
            m_row = 0;
        end
    endtask

    // Present a command (leaving cmd_valid high) and return once it is accepted
    task automatic applyStimulus(input int code, output int waited);
        waited = 0;
        cmd_valid = 1'b1;
        cmd_code = 5'(code);
        while (cmd_ready !== 1'b1 && waited < 5000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            checkOutput("ready timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            modelCmd(code);
        end
    endtask

    task automatic send(input int code);
        int w;
        applyStimulus(code, w);
    endtask

    task automatic sendRepeat(input int code, input int n);
        for (int i = 0; i < n; i++) send(code);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (text_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected write at addr", int'(waddr), -1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("write addr", int'(waddr), e.addr);
                checkOutput("write data", int'(new_char), e.data);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int bad_en;
        int bad_rdy;

        // Reset state
        #23;
        checkOutput("reset text_en", int'(text_en), 0);
        checkOutput("reset waddr", int'(waddr), 0);
        checkOutput("reset new_char", int'(new_char), 0);
        checkOutput("reset cmd_ready", int'(cmd_ready), 0);
        checkCursor("reset cursor", 0, 0);

        // Power-up clear
        for (int i = 0; i < CELLS; i++) pushWrite(i, BLANK);
        @(negedge clk);
        rst_n = 1'b1;
        bad_en = 0;
        bad_rdy = 0;
        for (int i = 1; i <= CELLS; i++) begin
            @(negedge clk);
            if (text_en !== 1'b1) bad_en++;
            if (cmd_ready !== (i == CELLS)) bad_rdy++;
        end
        checkOutput("power-up text_en gap cycles", bad_en, 0);
        checkOutput("power-up cmd_ready wrong cycles", bad_rdy, 0);
        @(negedge clk);
        checkOutput("post-clear text_en", int'(text_en), 0);
        checkOutput("post-clear cmd_ready", int'(cmd_ready), 1);
        checkCursor("post-clear cursor", 0, 0);
        @(posedge clk);
        #1;

        // Print at home, then a full line back-to-back
        send(5);
        idle();
        checkOutput("print5 text_en", int'(text_en), 1);
        checkOutput("print5 waddr", int'(waddr), 0);
        checkOutput("print5 new_char", int'(new_char), 5);
        checkCursor("after print5", 1, 0);
        @(posedge clk);
        #1;
        checkOutput("print5 strobe width", int'(text_en), 0);
        for (int i = 0; i < COLS; i++) send(i % 16);
        idle();
        checkOutput("burst last waddr", int'(waddr), 80);
        checkCursor("after 81 prints", 1, 1);

        // Newline from (10,2)
        send(19);
        sendRepeat(16, 2);
        sendRepeat(1, 10);
        idle();
        checkCursor("before newline", 10, 2);
        send(16);
        idle();
        checkOutput("newline text_en", int'(text_en), 0);
        checkCursor("after newline", 0, 3);

        // Newline wrap from last row
        send(19);
        sendRepeat(16, 29);
        idle();
        checkCursor("at last row", 0, 29);
        send(16);
        idle();
        checkCursor("after row wrap", 0, 0);

        // Home from (40,15)
        sendRepeat(16, 15);
        sendRepeat(3, 40);
        idle();
        checkCursor("before home", 40, 15);
        send(19);
        idle();
        checkOutput("home text_en", int'(text_en), 0);
        checkCursor("after home", 0, 0);

        // End-of-screen wrap
        sendRepeat(16, 29);
        sendRepeat(2, 79);
        idle();
        checkCursor("at last cell", 79, 29);
        send(9);
        idle();
        checkOutput("wrap waddr", int'(waddr), 2399);
        checkOutput("wrap new_char", int'(new_char), 9);
        checkCursor("after end wrap", 0, 0);

        // Backspace across a line start, within a line, and at origin
        send(16);
        send(17);
        idle();
        checkOutput("bksp line text_en", int'(text_en), 1);
        checkOutput("bksp line waddr", int'(waddr), 79);
        checkOutput("bksp line new_char", int'(new_char), 0);
        checkCursor("after bksp line", 79, 0);
        send(19);
        sendRepeat(4, 3);
        send(17);
        idle();
        checkOutput("bksp col waddr", int'(waddr), 2);
        checkCursor("after bksp col", 2, 0);
        send(19);
        send(17);
        idle();
        checkOutput("bksp origin text_en", int'(text_en), 0);
        checkCursor("after bksp origin", 0, 0);

        // Ignored code
        send(11);
        send(25);
        idle();
        checkOutput("noop text_en", int'(text_en), 0);
        checkCursor("after noop", 1, 0);

        // Clear with a glyph held pending
        send(18);
        checkOutput("clear start waddr", int'(waddr), 0);
        checkOutput("clear start cmd_ready", int'(cmd_ready), 0);
        checkCursor("clear start cursor", 0, 0);
        applyStimulus(7, w);
        idle();
        checkOutput("held glyph wait cycles", w, CELLS - 1);
        checkOutput("held glyph text_en", int'(text_en), 1);
        checkOutput("held glyph waddr", int'(waddr), 0);
        checkOutput("held glyph new_char", int'(new_char), 7);
        checkCursor("after held glyph", 1, 0);

        // Reset in the middle of a clear
        send(18);
        idle();
        repeat (1000) begin
            @(posedge clk);
            #1;
        end
        checkOutput("mid-clear waddr", int'(waddr), 1000);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-clear reset text_en", int'(text_en), 0);
        checkOutput("mid-clear reset waddr", int'(waddr), 0);
        checkOutput("mid-clear reset cmd_ready", int'(cmd_ready), 0);
        @(negedge clk);
        checkOutput("writes left after abort", exp_q.size(), CELLS - 1000);
        if (exp_q.size() > 0) checkOutput("first unwritten addr", exp_q[0].addr, 1000);
        exp_q.delete();
        for (int i = 0; i < CELLS; i++) pushWrite(i, BLANK);
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rst_n = 1'b1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 5000) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkOutput("restart clear cycles", w, CELLS);
        checkCursor("after restart", 0, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
